aclk_set_ctrl: RTL

- Button-driven setting controller that sequences the alarm clock core's load port: H_in1/H_in0/M_in1/M_in0 plus LD_time/LD_alarm.
- The user edits four digits (H1, H0, M1, M0) in order. The block enforces legal 24-hour values and issues a single-cycle load pulse to the clock or the alarm register.
- It sits between the debounced front-panel buttons and the alarm clock core. It runs on the same 10 Hz clock.

---
 rtl/aclk_set_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/aclk_set_ctrl.sv
// rtl/aclk_set_ctrl.sv - button-driven H1/H0/M1/M0 editor that loads the alarm clock core's time or alarm register
module aclk_set_ctrl #(
  parameter int unsigned TIMEOUT = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set_time,
  input  logic       btn_set_alarm,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic       edit_target,
  output logic [1:0] edit_digit,
  output logic       timeout_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT_H1,
    S_EDIT_H0,
    S_EDIT_M1,
    S_EDIT_M0,
    S_LOAD
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        target_q, target_d;
  logic [1:0]  h1_q, h1_d, sh_h1_q, sh_h1_d;
  logic [3:0]  h0_q, h0_d, sh_h0_q, sh_h0_d;
  logic [3:0]  m1_q, m1_d, sh_m1_q, sh_m1_d;
  logic [3:0]  m0_q, m0_d, sh_m0_q, sh_m0_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic [3:0]  btn_low_q, btn_low_d;

  logic [3:0]  btns;
  logic [3:0]  ev;
  logic        ev_time, ev_alarm, ev_inc, ev_next;
  logic        is_edit;
  logic [3:0]  h0_max;

  // Stores "button was low last cycle"; clearing it in reset makes a held button look already high.
  assign btns      = {btn_next, btn_inc, btn_set_alarm, btn_set_time};
  assign btn_low_d = ~btns;
  assign ev        = btns & btn_low_q;
  assign ev_time   = ev[0];
  assign ev_alarm  = ev[1];
  assign ev_inc    = ev[2];
  assign ev_next   = ev[3];

  assign is_edit = (state_q == S_EDIT_H1) || (state_q == S_EDIT_H0) ||
                   (state_q == S_EDIT_M1) || (state_q == S_EDIT_M0);
  assign h0_max  = (h1_q == 2'd2) ? 4'd3 : 4'd9;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      target_q  <= 1'b0;
      h1_q      <= '0;
      h0_q      <= '0;
      m1_q      <= '0;
      m0_q      <= '0;
      sh_h1_q   <= '0;
      sh_h0_q   <= '0;
      sh_m1_q   <= '0;
      sh_m0_q   <= '0;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
      btn_low_q <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      h1_q      <= h1_d;
      h0_q      <= h0_d;
      m1_q      <= m1_d;
      m0_q      <= m0_d;
      sh_h1_q   <= sh_h1_d;
      sh_h0_q   <= sh_h0_d;
      sh_m1_q   <= sh_m1_d;
      sh_m0_q   <= sh_m0_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      btn_low_q <= btn_low_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    h1_d     = h1_q;
    h0_d     = h0_q;
    m1_d     = m1_q;
    m0_d     = m0_q;
    sh_h1_d  = sh_h1_q;
    sh_h0_d  = sh_h0_q;
    sh_m1_d  = sh_m1_q;
    sh_m0_d  = sh_m0_q;
    cnt_d    = '0;
    tmo_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ev_time) begin
          state_d  = S_EDIT_H1;
          target_d = 1'b0;
          h1_d     = cur_H1;
          h0_d     = cur_H0;
          m1_d     = cur_M1;
          m0_d     = cur_M0;
        end else if (ev_alarm) begin
          state_d  = S_EDIT_H1;
          target_d = 1'b1;
          h1_d     = sh_h1_q;
          h0_d     = sh_h0_q;
          m1_d     = sh_m1_q;
          m0_d     = sh_m0_q;
        end
      end

      S_EDIT_H1, S_EDIT_H0, S_EDIT_M1, S_EDIT_M0: begin
        cnt_d = cnt_q + 16'd1;
        // An accepted event in the timeout cycle keeps the edit alive.
        if (ev_next) begin
          cnt_d = '0;
          case (state_q)
            S_EDIT_H1: state_d = S_EDIT_H0;
            S_EDIT_H0: state_d = S_EDIT_M1;
            S_EDIT_M1: state_d = S_EDIT_M0;
            default:   state_d = S_LOAD;
          endcase
        end else if (ev_inc) begin
          cnt_d = '0;
          case (state_q)
            S_EDIT_H1: begin
              h1_d = (h1_q >= 2'd2) ? 2'd0 : h1_q + 2'd1;
              if ((h1_q == 2'd1) && (h0_q > 4'd3)) h0_d = 4'd3;
            end
            S_EDIT_H0: h0_d = (h0_q >= h0_max) ? 4'd0 : h0_q + 4'd1;
            S_EDIT_M1: m1_d = (m1_q >= 4'd5) ? 4'd0 : m1_q + 4'd1;
            default:   m0_d = (m0_q >= 4'd9) ? 4'd0 : m0_q + 4'd1;
          endcase
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end
      end

      S_LOAD: begin
        state_d = S_IDLE;
        if (target_q) begin
          sh_h1_d = h1_q;
          sh_h0_d = h0_q;
          sh_m1_d = m1_q;
          sh_m0_d = m0_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    edit_digit = 2'd0;
    case (state_q)
      S_EDIT_H0: edit_digit = 2'd1;
      S_EDIT_M1: edit_digit = 2'd2;
      S_EDIT_M0: edit_digit = 2'd3;
      default:   edit_digit = 2'd0;
    endcase
  end

  assign H_in1        = h1_q;
  assign H_in0        = h0_q;
  assign M_in1        = m1_q;
  assign M_in0        = m0_q;
  assign LD_time      = (state_q == S_LOAD) && !target_q;
  assign LD_alarm     = (state_q == S_LOAD) && target_q;
  assign editing      = is_edit;
  assign edit_target  = target_q;
  assign timeout_flag = tmo_q;

endmodule
